// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-side drain stage for the async FIFO (FIFO read clock domain).
//   Pops DATA_WIDTH-bit entries through Rd_Req/Empty/D_IN, where D_IN is
//   valid one cycle after an accepted Rd_Req. Packs PACK_RATIO consecutive
//   entries into one wide word, with the first entry in the LSB lane. The
//   word is presented on a valid/ready master port, and the FIFO absorbs
//   all back-pressure.
//
// Optional feature macro: PACK_FLUSH_EN
//   When defined, this adds Flush/M_BYTES so that a partial word can be
//   pushed out. Unused lanes of a partial word read as zero.
//
// Ports
//   CLK       in   FIFO read-domain clock
//   rst       in   synchronous active-high reset
//   Empty     in   FIFO empty flag
//   D_IN      in   FIFO read data (registered, one cycle after Rd_Req)
//   Rd_Req    out  FIFO read request (combinational)
//   M_DATA    out  packed word, lane k = [k*DATA_WIDTH +: DATA_WIDTH]
//   M_VALID   out  M_DATA holds a word
//   M_READY   in   downstream accept
//   Fill_Cnt  out  lanes currently captured in the accumulator
//   Flush     in   (PACK_FLUSH_EN) request to emit a partial word
//   M_BYTES   out  (PACK_FLUSH_EN) number of valid lanes in M_DATA
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4,
  parameter int CNT_WIDTH  = $clog2(PACK_RATIO + 1)
) (
  input  logic                             CLK,
  input  logic                             rst,
  input  logic                             Empty,
  input  logic [DATA_WIDTH-1:0]            D_IN,
  output logic                             Rd_Req,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] M_DATA,
  output logic                             M_VALID,
  input  logic                             M_READY,
  output logic [CNT_WIDTH-1:0]             Fill_Cnt
`ifdef PACK_FLUSH_EN
  ,
  input  logic                             Flush,
  output logic [CNT_WIDTH-1:0]             M_BYTES
`endif
);

  localparam int unsigned          LANES   = PACK_RATIO;
  localparam logic [CNT_WIDTH-1:0] FULL    = CNT_WIDTH'(PACK_RATIO);
  localparam logic [CNT_WIDTH:0]   RATIO_W = (CNT_WIDTH+1)'(PACK_RATIO);

  logic                             rd_pend;
  logic [DATA_WIDTH*PACK_RATIO-1:0] acc;
  logic                             slot_free;
  logic                             xfer_full;
  logic                             xfer;
  logic                             issue_ok;
  logic [CNT_WIDTH:0]               occupancy;

  // Lanes already captured plus the one still in flight from the FIFO.
  assign occupancy = {1'b0, Fill_Cnt} + {{CNT_WIDTH{1'b0}}, rd_pend};
  assign slot_free = !M_VALID || M_READY;
  assign xfer_full = (Fill_Cnt == FULL) && slot_free;

`ifdef PACK_FLUSH_EN
  logic flush_pend;
  logic flush_go;
  logic flush_xfer;

  // Reads are held off while a flush is pending. So once rd_pend drains,
  // Fill_Cnt is final and the partial word can be emitted.
  assign flush_go   = flush_pend && !rd_pend && slot_free;
  assign flush_xfer = flush_go && (Fill_Cnt != '0);
  assign issue_ok   = !flush_pend;
  assign xfer       = xfer_full || flush_xfer;
`else
  assign issue_ok   = 1'b1;
  assign xfer       = xfer_full;
`endif

  assign Rd_Req = !rst && !Empty && issue_ok && (occupancy < RATIO_W);

  always_ff @(posedge CLK) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      acc      <= '0;
      M_DATA   <= '0;
      M_VALID  <= 1'b0;
      Fill_Cnt <= '0;
`ifdef PACK_FLUSH_EN
      flush_pend <= 1'b0;
      M_BYTES    <= '0;
`endif
    end else begin
      rd_pend <= Rd_Req;
`ifdef PACK_FLUSH_EN
      flush_pend <= Flush || (flush_pend && !flush_go);
`endif
      if (xfer) begin
        // The issue rule guarantees rd_pend=0 here, so no capture is lost.
        // The accumulator is cleared so that a later partial word has
        // zeroed upper lanes.
        M_DATA   <= acc;
        M_VALID  <= 1'b1;
        Fill_Cnt <= '0;
        acc      <= '0;
`ifdef PACK_FLUSH_EN
        M_BYTES  <= Fill_Cnt;
`endif
      end else begin
        if (M_VALID && M_READY) begin
          M_VALID <= 1'b0;
        end
        if (rd_pend) begin
          for (int unsigned k = 0; k < LANES; k++) begin
            if (Fill_Cnt == CNT_WIDTH'(k)) begin
              acc[k*DATA_WIDTH +: DATA_WIDTH] <= D_IN;
            end
          end
          Fill_Cnt <= Fill_Cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer. A queue-based FIFO model drives Empty/D_IN and
// responds to Rd_Req with one-cycle registered data. Inputs are driven on the
// falling edge, and outputs are sampled 1 time unit later.
module tb_fifo_rd_packer;
  localparam int DW = 8;
  localparam int PR = 4;
  localparam int CW = $clog2(PR + 1);
  localparam int MW = DW * PR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          empty;
  logic          m_ready;
  logic          rd_req;
  logic          m_valid;
  logic [DW-1:0] d_in = '0;
  logic [MW-1:0] m_data;
  logic [CW-1:0] fill_cnt;
`ifdef PACK_FLUSH_EN
  logic          flush;
  logic [CW-1:0] m_bytes;
`endif

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
    .CLK      (clk),
    .rst      (rst),
    .Empty    (empty),
    .D_IN     (d_in),
    .Rd_Req   (rd_req),
    .M_DATA   (m_data),
    .M_VALID  (m_valid),
    .M_READY  (m_ready),
    .Fill_Cnt (fill_cnt)
`ifdef PACK_FLUSH_EN
    ,
    .Flush    (flush),
    .M_BYTES  (m_bytes)
`endif
  );

  int errors = 0;
  int checks = 0;
  int words_out = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          hold_empty;

  logic          s_valid;
  logic          s_req;
  logic [MW-1:0] s_data;
  logic [CW-1:0] s_fill;
  logic [CW-1:0] s_bytes;

  // FIFO model: registered read data.
  always @(posedge clk) begin
    if (rd_req && fifo_q.size() > 0) d_in <= fifo_q.pop_front();
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
  endtask

  // One clock cycle. This task is entered at a falling edge with the inputs
  // already set. It samples, runs the protocol monitors and scoreboard, and
  // then waits for the next falling edge.
  task automatic tick();
    logic [MW-1:0] ew;
    int nb;
    int occ;
    empty = hold_empty || (fifo_q.size() == 0);
    #1;
    s_valid = m_valid;
    s_req   = rd_req;
    s_data  = m_data;
    s_fill  = fill_cnt;
    s_bytes = CW'(PR);
`ifdef PACK_FLUSH_EN
    s_bytes = m_bytes;
`endif
    check("rd_req_while_empty", 64'(rd_req & empty), 64'd0);
    occ = int'(fill_cnt) + int'(dut.rd_pend);
    check("occupancy_le_ratio", 64'(occ > PR), 64'd0);
    if (m_valid && m_ready && !rst) begin
      nb = int'(s_bytes);
      ew = '0;
      for (int k = 0; k < nb; k++) begin
        if (exp_q.size() > 0) ew[k*DW +: DW] = exp_q.pop_front();
      end
      check("stream_word", 64'(m_data), 64'(ew));
      words_out++;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic          he;
    logic          mr;
    logic          req;
    logic          valid;
    logic [CW-1:0] fill;
    logic [MW-1:0] data;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int got;
    int nvalid;

    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, CW'(0), 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, CW'(0), 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, CW'(1), 32'h0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, CW'(2), 32'h0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, CW'(3), 32'h0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, CW'(4), 32'h0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, CW'(0), 32'h44332211};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, CW'(0), 32'h0};

    rst = 1'b1;
    m_ready = 1'b0;
    hold_empty = 1'b0;
    empty = 1'b1;
`ifdef PACK_FLUSH_EN
    flush = 1'b0;
`endif
    // The FIFO already holds data during reset, so Rd_Req must be forced low.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    @(negedge clk);
    tick();
    tick();
    check("reset_valid", 64'(s_valid), 64'd0);
    check("reset_data", 64'(s_data), 64'd0);
    check("reset_fill", 64'(s_fill), 64'd0);
    check("reset_rd_req", 64'(s_req), 64'd0);

    // First word: table-driven, cycle by cycle.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hold_empty = tbl[i].he;
      m_ready = tbl[i].mr;
      tick();
      check($sformatf("t1_rd_req[%0d]", i), 64'(s_req), 64'(tbl[i].req));
      check($sformatf("t1_valid[%0d]", i), 64'(s_valid), 64'(tbl[i].valid));
      check($sformatf("t1_fill[%0d]", i), 64'(s_fill), 64'(tbl[i].fill));
      if (tbl[i].valid) check($sformatf("t1_data[%0d]", i), 64'(s_data), 64'(tbl[i].data));
    end

    // Back-pressure: two words while downstream is stalled until cycle 20.
    for (int i = 1; i <= 8; i++) push(DW'(i));
    for (int c = 0; c <= 22; c++) begin
      m_ready = (c >= 20);
      tick();
      if (c == 5) check("bp_valid_c5", 64'(s_valid), 64'd0);
      if (c >= 6 && c <= 20) begin
        check($sformatf("bp_hold_valid[%0d]", c), 64'(s_valid), 64'd1);
        check($sformatf("bp_hold_data[%0d]", c), 64'(s_data), 64'h04030201);
      end
      if (c >= 11 && c <= 20) begin
        check($sformatf("bp_full_fill[%0d]", c), 64'(s_fill), 64'(PR));
        check($sformatf("bp_full_rdreq[%0d]", c), 64'(s_req), 64'd0);
      end
      if (c == 21) begin
        check("bp_word2_valid", 64'(s_valid), 64'd1);
        check("bp_word2_data", 64'(s_data), 64'h08070605);
      end
      if (c == 22) check("bp_valid_clear", 64'(s_valid), 64'd0);
    end

    // Empty toggling after every entry.
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    m_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      hold_empty = c[0];
      tick();
      if (s_valid) begin
        check("toggle_word", 64'(s_data), 64'hC4C3C2C1);
        got = 1;
        break;
      end
    end
    check("toggle_word_seen", 64'(got), 64'd1);
    hold_empty = 1'b0;
    tick(); tick(); tick();

    // Reset mid-word, with Fill_Cnt=2 and rd_pend=1.
    push(8'h51); push(8'h52); push(8'h53);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("pre_reset_fill", 64'(s_fill), 64'd2);
    rst = 1'b0;
    exp_q.delete();
    tick();
    check("post_reset_valid", 64'(s_valid), 64'd0);
    check("post_reset_fill", 64'(s_fill), 64'd0);
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    got = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (s_valid) begin
        check("post_reset_word", 64'(s_data), 64'hA3A2A1A0);
        got = 1;
        break;
      end
    end
    check("post_reset_word_seen", 64'(got), 64'd1);
    tick(); tick();

`ifdef PACK_FLUSH_EN
    // Partial-word flush.
    push(8'hAA); push(8'hBB);
    tick(); tick(); tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (s_valid) begin
        check("flush_data", 64'(s_data), 64'h0000BBAA);
        check("flush_bytes", 64'(s_bytes), 64'd2);
        got = 1;
        break;
      end
    end
    check("flush_word_seen", 64'(got), 64'd1);
    tick(); tick(); tick();
    // A flush with an empty accumulator emits nothing.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (s_valid) nvalid++;
    end
    check("flush_empty_no_word", 64'(nvalid), 64'd0);
    check("flush_empty_fill", 64'(s_fill), 64'd0);
`else
    nvalid = 0;
`endif

    // Random Empty / M_READY, checked by the scoreboard and monitors.
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) push(DW'($urandom));
      hold_empty = ($urandom_range(0, 3) == 0);
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    while ((exp_q.size() % PR) != 0) push(DW'($urandom));
    hold_empty = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (exp_q.size() == 0 && !s_valid) break;
      tick();
    end
    check("drain_complete", 64'(exp_q.size()), 64'd0);
    check("words_emitted", 64'(words_out > 100), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side drain stage for the async FIFO, running in the FIFO read clock domain.
- Pops FIFO_WIDTH-bit entries using the FIFO's Rd_Req/Empty/D_OUT interface, which has one-cycle registered read data.
- Packs PACK_RATIO consecutive entries into one wide word, first entry in the LSB lane.
- Presents packed words on a valid/ready master interface with back-pressure; the FIFO absorbs all stalls.

Parameters:
- DATA_WIDTH, 8, width of one FIFO entry (matches the FIFO's FIFO_WIDTH).
- PACK_RATIO, 4, entries per output word; must be ≥ 2.
- CNT_WIDTH, $clog2(PACK_RATIO+1), width of fill/in-flight counters.

Ports:
- CLK  input  1  FIFO read-domain clock (rCLK of the FIFO).
- rst  input  1  synchronous active-high reset.
- Empty  input  1  FIFO Empty flag.
- D_IN  input  DATA_WIDTH  FIFO D_OUT; valid the cycle after an accepted Rd_Req.
- Rd_Req  output  1  FIFO read request; combinational.
- M_DATA  output  DATA_WIDTH*PACK_RATIO  packed word; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- M_VALID  output  1  M_DATA holds a word.
- M_READY  input  1  downstream accepts the word when M_VALID && M_READY at a rising edge.
- Fill_Cnt  output  CNT_WIDTH  lanes currently captured in the accumulator (status).

Behaviour:
- Reset (rst=1 at a CLK edge):
  - M_VALID=0, M_DATA=0, Fill_Cnt=0, rd_pend=0, accumulator=0.
  - Rd_Req is forced 0 while rst=1.
  - Reset mid-word discards partial data. FIFO entries already popped are lost; this is accepted.
- rd_pend: a register set to Rd_Req every cycle. It marks that D_IN is valid this cycle.
- Rd_Req = !rst && !Empty && (Fill_Cnt + rd_pend < PACK_RATIO).
  - Rd_Req is never asserted while Empty=1, so every asserted Rd_Req is accepted by the FIFO.
- Capture: when rd_pend=1, accumulator lane[Fill_Cnt] <= D_IN and Fill_Cnt increments.
- Transfer: when Fill_Cnt == PACK_RATIO and (!M_VALID || M_READY):
  - M_DATA <= accumulator, M_VALID <= 1, Fill_Cnt <= 0.
  - rd_pend is guaranteed 0 in this cycle by the issue rule, so no capture collides with a transfer.
- Handshake:
  - If M_VALID && M_READY and no transfer occurs, M_VALID <= 0.
  - M_DATA is held stable while M_VALID && !M_READY.
- Stall: Fill_Cnt stays at PACK_RATIO and Rd_Req=0 until the output slot frees.
- Latency: first Rd_Req to M_VALID = PACK_RATIO+2 cycles.
- Throughput: steady state is one word per PACK_RATIO+2 cycles with M_READY=1 and Empty=0.
- Empty mid-word: Rd_Req drops, the accumulator holds its lanes, and filling resumes when Empty deasserts. No timeout.
- Fill_Cnt + rd_pend never exceeds PACK_RATIO; the verification engineer asserts this.

Optional Feature:
- Macro: PACK_FLUSH_EN.
- Defined:
  - Adds input Flush (1 bit) and output M_BYTES (CNT_WIDTH).
  - A Flush pulse sets flush_pend; Rd_Req is forced 0 while flush_pend=1.
  - Once rd_pend=0 and the slot is free:
    - If Fill_Cnt>0, a partial word transfers. Unused lanes are 0, M_BYTES=Fill_Cnt, Fill_Cnt<=0, and flush_pend clears.
    - If Fill_Cnt==0, flush_pend clears with no output.
  - Full words report M_BYTES=PACK_RATIO.
  - Flush arriving while Fill_Cnt==PACK_RATIO: the full word transfers normally, then flush_pend clears.
  - Reset clears flush_pend and M_BYTES.
- Undefined: no Flush or M_BYTES ports; partial words wait indefinitely for more data.

Test Plan:
- Reset then Empty=0 and M_READY=1, with FIFO holding 0x11,0x22,0x33,0x44 -> Rd_Req high cycles 0-3; M_VALID=1 in cycle 6; M_DATA=0x44332211; Fill_Cnt=0.
- 8 entries 0x01..0x08 with M_READY=0 until cycle 20 -> first word 0x04030201 held stable; Rd_Req=0 while Fill_Cnt=4; second word 0x08070605 follows after the handshake.
- Empty toggles after every entry -> Rd_Req never high while Empty=1; the word is assembled correctly (lanes in order).
- rst pulse while Fill_Cnt=2 and rd_pend=1 -> next cycle M_VALID=0 and Fill_Cnt=0; subsequent entries 0xA0..0xA3 produce 0xA3A2A1A0.
- PACK_FLUSH_EN: 0xAA,0xBB then Flush -> M_VALID with M_DATA=0x0000BBAA and M_BYTES=2; a Flush with Fill_Cnt=0 produces no M_VALID.
- Random Empty and M_READY over 10k cycles -> output stream equals FIFO input stream; Fill_Cnt+rd_pend ≤ PACK_RATIO is never violated.
